// File: rtl/datamem_vec_seq.sv
// Data-memory responder: one-cycle scalar word/byte access, VLEN-wide vector access
// as NB sequential word beats with busy stall and done pulse. Option: MISALIGN_TRAP_EN.
// Ports: clk, clrn (async low), addr, wdata, wmem, vector, vreq -> mem, busy, done
//        [+ misalign when MISALIGN_TRAP_EN is defined]
module datamem_vec_seq #(
  parameter int VLEN  = 128,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [31:0]     addr,
  input  logic [VLEN-1:0] wdata,
  input  logic [3:0]      wmem,
  input  logic            vector,
  input  logic            vreq,
  output logic [VLEN-1:0] mem,
  output logic            busy,
  output logic            done
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  localparam int NB = VLEN / 32;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]     ram [DEPTH];
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   base;
  logic [AW-1:0]   bidx;
  logic [VLEN-1:0] wbuf;
  logic [VLEN-1:0] rbuf;
  logic [3:0]      wmask;
  logic            wr;
  logic            last;
  logic            vgo;
  logic            swe;
  logic            unused;

  assign idx  = addr[AW+1:2];
  assign bidx = base + AW'(cnt);
  assign last = (cnt == CW'(NB - 1));

  // vgo: vector request accepted this cycle; swe: scalar write allowed
`ifdef MISALIGN_TRAP_EN
  logic vmis;
  logic smis;

  assign vmis = |addr[CW+1:0];
  assign smis = (wmem == 4'hF) && (|addr[1:0]);
  assign vgo  = clrn && (state == IDLE) && vreq && vector && !vmis;
  assign swe  = clrn && (state == IDLE) && !vector && !smis;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      misalign <= 1'b0;
    end else begin
      misalign <= (state == IDLE) &&
                  ((vreq && vector && vmis) || (!vector && smis));
    end
  end
`else
  assign vgo = clrn && (state == IDLE) && vreq && vector;
  assign swe = clrn && (state == IDLE) && !vector;
`endif

  assign unused = ^{addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (vgo) state_nx = BEAT;
      BEAT:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = vgo || (state == BEAT);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt   <= '0;
      base  <= '0;
      wbuf  <= '0;
      rbuf  <= '0;
      wmask <= '0;
      wr    <= 1'b0;
    end else if (vgo) begin
      base  <= idx & ~AW'(NB - 1);
      wbuf  <= wdata;
      wmask <= wmem;
      wr    <= |wmem;
      cnt   <= '0;
    end else if (state == BEAT) begin
      cnt <= cnt + 1'b1;
      if (!wr) rbuf[32*cnt +: 32] <= ram[bidx];
    end
  end

  // Backing store is deliberately not reset
  always_ff @(posedge clk) begin
    if (swe) begin
      for (int i = 0; i < 4; i++)
        if (wmem[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
    end else if ((state == BEAT) && wr) begin
      for (int i = 0; i < 4; i++)
        if (wmask[i])
          ram[bidx][8*i +: 8] <= wbuf[32*cnt + 8*i +: 8];
    end
  end

  assign mem = vector ? rbuf : VLEN'(ram[idx]);

endmodule

// File: tb/tb_datamem_vec_seq.sv
// Bench for datamem_vec_seq: directed steps plus random scalar/vector traffic
// checked against a word-array reference model.
module tb_datamem_vec_seq;

  localparam int VLEN  = 128;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int NB    = VLEN / 32;

  logic            clk;
  logic            clrn;
  logic [31:0]     addr;
  logic [VLEN-1:0] wdata;
  logic [3:0]      wmem;
  logic            vector;
  logic            vreq;
  logic [VLEN-1:0] mem;
  logic            busy;
  logic            done;
`ifdef MISALIGN_TRAP_EN
  logic            misalign;
`endif

  datamem_vec_seq #(.VLEN(VLEN), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .clrn(clrn),
    .addr(addr),
    .wdata(wdata),
    .wmem(wmem),
    .vector(vector),
    .vreq(vreq),
    .mem(mem),
    .busy(busy),
    .done(done)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign(misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]     mdl [DEPTH];
  logic [VLEN-1:0] mrbuf;
  int              vecs = 0;
  int              errs = 0;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [VLEN-1:0] obs,
                     input logic [VLEN-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic int unsigned vbase(input logic [31:0] a);
    return ((a >> 2) % DEPTH) / NB * NB;
  endfunction

  task automatic mwrite(input int unsigned w, input logic [31:0] d,
                        input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (m[i]) mdl[w][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic swrite(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input bit check);
    @(negedge clk);
    vector = 1'b0;
    vreq   = 1'b0;
    addr   = a;
    wdata  = VLEN'(d);
    wmem   = m;
    #1;
    if (check) chk("scalar_busy", busy, '0);
    mwrite(widx(a), d, m);
  endtask

  task automatic sread(input logic [31:0] a, input string tag,
                       output logic [31:0] obs);
    @(negedge clk);
    vector = 1'b0;
    vreq   = 1'b0;
    wmem   = 4'h0;
    addr   = a;
    #1;
    chk(tag, mem, VLEN'(mdl[widx(a)]));
    obs = mem[31:0];
  endtask

  task automatic vop(input logic [31:0] a, input logic [VLEN-1:0] d,
                     input logic [3:0] m, input bit scramble);
    int          n;
    int unsigned b;
    @(negedge clk);
    addr   = a;
    wdata  = d;
    wmem   = m;
    vector = 1'b1;
    vreq   = 1'b1;
    #1;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
      if (scramble) begin
        addr  = $urandom;
        wdata = {$urandom, $urandom, $urandom, $urandom};
        wmem  = 4'($urandom);
      end
      #1;
    end
    chk("busy_len", n, NB + 1);
    chk("done_hi", done, 1);
    b = vbase(a);
    for (int k = 0; k < NB; k++) begin
      if (m != 4'h0) mwrite((b + k) % DEPTH, d[32*k +: 32], m);
      else mrbuf[32*k +: 32] = mdl[(b + k) % DEPTH];
    end
    if (m == 4'h0) chk("vload", mem, mrbuf);
    @(negedge clk);
    vreq   = 1'b0;
    vector = 1'b0;
    wmem   = 4'h0;
    #1;
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask

  logic [31:0]     r;
  logic [VLEN-1:0] vd;
  logic [31:0]     ra;
  int unsigned     op;

  initial begin
    clrn   = 1'b0;
    addr   = '0;
    wdata  = '0;
    wmem   = 4'h0;
    vector = 1'b1;
    vreq   = 1'b0;
    mrbuf  = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rbuf", mem, '0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_mis", misalign, 0);
`endif
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < DEPTH; i++) swrite(32'(i * 4), $urandom, 4'hF, 1'b0);

    // step 1 / 2: scalar word and byte writes
    swrite(32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    sread(32'h10, "s_rd1", r);
    chk("s_word", r, 32'hDEADBEEF);
    swrite(32'h10, 32'h00AA0000, 4'b0100, 1'b1);
    sread(32'h10, "s_rd2", r);
    chk("s_byte", r, 32'hDEAABEEF);

    // step 3: vector store
    vd = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    vop(32'h20, vd, 4'hF, 1'b0);
    sread(32'h20, "v_w0", r);
    chk("v_w0c", r, 32'hCCDDEEFF);
    sread(32'h24, "v_w1", r);
    chk("v_w1c", r, 32'h8899AABB);
    sread(32'h28, "v_w2", r);
    chk("v_w2c", r, 32'h44556677);
    sread(32'h2C, "v_w3", r);
    chk("v_w3c", r, 32'h00112233);

    // step 4: vector load, inputs churn and vreq held during beats
    vop(32'h20, '0, 4'h0, 1'b1);
    @(negedge clk);
    vector = 1'b1;
    #1;
    chk("rbuf_hold", mem, vd);

    // step 5: top of memory and wrap
    vop(32'hFF0, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) sread(32'hFF0 + 32'(4 * i), "top_w", r);
    sread(32'h0, "top_w0", r);
    vop(32'h1000, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) sread(32'(4 * i), "wrap_w", r);

    // step 6: reset after two beats of a store
    vd = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    addr   = 32'h0;
    wdata  = vd;
    wmem   = 4'hF;
    vector = 1'b1;
    vreq   = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rbuf", mem, '0);
    mwrite(0, vd[31:0], 4'hF);
    mwrite(1, vd[63:32], 4'hF);
    @(negedge clk);
    vreq = 1'b0;
    clrn = 1'b1;
    #1;
    chk("abort_idle", busy, 0);
    for (int i = 0; i < 4; i++) sread(32'(4 * i), "abort_w", r);

`ifdef MISALIGN_TRAP_EN
    sread(32'h24, "mis_pre", r);
    @(negedge clk);
    addr   = 32'h24;
    wdata  = {$urandom, $urandom, $urandom, $urandom};
    wmem   = 4'hF;
    vector = 1'b1;
    vreq   = 1'b1;
    #1;
    chk("mis_v_busy", busy, 0);
    @(negedge clk);
    vreq   = 1'b0;
    vector = 1'b0;
    wmem   = 4'h0;
    #1;
    chk("mis_v_flag", misalign, 1);
    chk("mis_v_idle", done, 0);
    @(negedge clk);
    #1;
    chk("mis_v_drop", misalign, 0);
    for (int i = 0; i < 4; i++) sread(32'h20 + 32'(4 * i), "mis_v_nowr", r);
    @(negedge clk);
    addr  = 32'h11;
    wdata = VLEN'(32'h12345678);
    wmem  = 4'hF;
    #1;
    @(negedge clk);
    wmem = 4'h0;
    #1;
    chk("mis_s_flag", misalign, 1);
    sread(32'h10, "mis_s_nowr", r);
`else
    vop(32'h24, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) sread(32'h20 + 32'(4 * i), "align_v", r);
    swrite(32'h13, 32'hA5A5_5A5A, 4'hF, 1'b1);
    sread(32'h10, "align_s", r);
`endif

    // random traffic
    for (int t = 0; t < 300; t++) begin
      op = $urandom_range(0, 3);
      ra = $urandom;
      case (op)
        0: swrite(ra & ~32'h3, $urandom, 4'($urandom), 1'b1);
        1: sread(ra & ~32'h3, "rnd_sread", r);
        2: vop(ra & ~32'(NB * 4 - 1),
               {$urandom, $urandom, $urandom, $urandom},
               4'($urandom_range(1, 15)), 1'b1);
        default: vop(ra & ~32'(NB * 4 - 1), '0, 4'h0, 1'b1);
      endcase
    end
    for (int i = 0; i < DEPTH; i += 37) sread(32'(i * 4), "final_scan", r);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
